// File: rtl/cim_pkg.sv
// Shared types and constants for the CIM weight-load controller.
package cim_pkg;

    localparam int CIM_DATA_W = 24;
    localparam int CIM_ROWS   = 8;
    localparam int CIM_HALF_W = CIM_DATA_W / 2;
    localparam int CIM_PTR_W  = $clog2(CIM_ROWS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } cim_state_e;

    function automatic logic [CIM_ROWS-1:0] onehot_row(input logic [CIM_PTR_W-1:0] idx);
        logic [CIM_ROWS-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/cim_wload_ctrl_if.sv
// Valid/ready weight stream between the DMA/host source and the load controller.
interface cim_wload_ctrl_if
    import cim_pkg::*;
#(
    parameter int DATA_W = CIM_DATA_W
) ();

    logic              s_valid;
    logic [DATA_W-1:0] s_data;
    logic              s_ready;

    modport master (output s_valid, output s_data, input  s_ready);
    modport slave  (input  s_valid, input  s_data, output s_ready);

endinterface

// File: rtl/cim_wload_rbchk.sv
// Readback comparator: checks the bank's inverted lane outputs for the row just written.
module cim_wload_rbchk
    import cim_pkg::*;
#(
    parameter int DATA_W = CIM_DATA_W,
    parameter int ROWS   = CIM_ROWS
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        clear_i,
    input  logic                        check_i,
    input  logic [$clog2(ROWS)-1:0]     row_i,
    input  logic [DATA_W-1:0]           d_i,
    input  logic [ROWS*(DATA_W/2)-1:0]  wb_a_i,
    input  logic [ROWS*(DATA_W/2)-1:0]  wb_b_i,
    output logic                        rb_err_o
);

    localparam int HALF_W = DATA_W / 2;

    logic [HALF_W-1:0] lane_a;
    logic [HALF_W-1:0] lane_b;
    logic              mismatch;
    logic              err_q;

    assign lane_a   = wb_a_i[int'(row_i) * HALF_W +: HALF_W];
    assign lane_b   = wb_b_i[int'(row_i) * HALF_W +: HALF_W];
    assign mismatch = check_i && ((lane_a != ~d_i[HALF_W-1:0]) ||
                                  (lane_b != ~d_i[DATA_W-1:HALF_W]));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (clear_i) begin
            err_q <= 1'b0;
        end else if (mismatch) begin
            err_q <= 1'b1;
        end
    end

    // Flag is visible in the strobe cycle itself, then held by err_q.
    assign rb_err_o = err_q | mismatch;

endmodule

// File: rtl/cim_wload_ctrl.sv
// Weight-row load sequencer for a CIM bank write port.
// Optional readback verification is built when CIM_WLOAD_READBACK_EN is defined.
module cim_wload_ctrl
    import cim_pkg::*;
#(
    parameter int DATA_W = CIM_DATA_W,
    parameter int ROWS   = CIM_ROWS
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic [$clog2(ROWS)-1:0]     base_row,
    input  logic [$clog2(ROWS):0]       row_count,
    input  logic                        abort,
    cim_wload_ctrl_if.slave             s,
    output logic [DATA_W-1:0]           D,
    output logic [ROWS-1:0]             WA,
    output logic                        wr_strobe,
    output logic                        busy,
    output logic                        done
`ifdef CIM_WLOAD_READBACK_EN
   ,input  logic [ROWS*(DATA_W/2)-1:0]  WB_a,
    input  logic [ROWS*(DATA_W/2)-1:0]  WB_b,
    output logic                        rb_err
`endif
);

    localparam int PTR_W = $clog2(ROWS);
    localparam int CNT_W = PTR_W + 1;

    cim_state_e        state_q, state_d;
    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic [CNT_W-1:0]  rem_q, rem_d;
    logic              s_ready_q, s_ready_d;
    logic [DATA_W-1:0] d_q, d_d;
    logic [ROWS-1:0]   wa_q, wa_d;
    logic              wr_strobe_q, wr_strobe_d;

    logic              start_ok;
    logic              accept;
    logic [CNT_W-1:0]  cnt_sat;

    // abort outranks both a new start and a same-cycle handshake.
    assign start_ok = (state_q == IDLE) && start && !abort;
    assign accept   = (state_q == LOAD) && s_ready_q && s.s_valid && !abort;
    assign cnt_sat  = (row_count > CNT_W'(ROWS)) ? CNT_W'(ROWS) : row_count;

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        rem_d       = rem_q;
        s_ready_d   = s_ready_q;
        d_d         = d_q;
        wa_d        = wa_q;
        wr_strobe_d = 1'b0;
        if (abort) begin
            state_d   = IDLE;
            s_ready_d = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start_ok) begin
                        if (cnt_sat == '0) begin
                            state_d = DONE;
                        end else begin
                            state_d   = LOAD;
                            ptr_d     = base_row;
                            rem_d     = cnt_sat;
                            s_ready_d = 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (accept) begin
                        d_d         = s.s_data;
                        wa_d        = onehot_row(ptr_q);
                        wr_strobe_d = 1'b1;
                        ptr_d       = ptr_q + PTR_W'(1);
                        rem_d       = rem_q - CNT_W'(1);
                        if (rem_q == CNT_W'(1)) begin
                            s_ready_d = 1'b0;
                            state_d   = DONE;
                        end
                    end
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            rem_q       <= '0;
            s_ready_q   <= 1'b0;
            d_q         <= '0;
            wa_q        <= ROWS'(1);
            wr_strobe_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            rem_q       <= rem_d;
            s_ready_q   <= s_ready_d;
            d_q         <= d_d;
            wa_q        <= wa_d;
            wr_strobe_q <= wr_strobe_d;
        end
    end

    assign s.s_ready = s_ready_q;
    assign D         = d_q;
    assign WA        = wa_q;
    assign wr_strobe = wr_strobe_q;
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);

`ifdef CIM_WLOAD_READBACK_EN
    logic [PTR_W-1:0] row_q;

    // Row index tracks WA so the comparator needs no one-hot decode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_q <= '0;
        end else if (accept) begin
            row_q <= ptr_q;
        end
    end

    cim_wload_rbchk #(
        .DATA_W (DATA_W),
        .ROWS   (ROWS)
    ) u_rbchk (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear_i  (start_ok),
        .check_i  (wr_strobe_q),
        .row_i    (row_q),
        .d_i      (d_q),
        .wb_a_i   (WB_a),
        .wb_b_i   (WB_b),
        .rb_err_o (rb_err)
    );
`endif

endmodule

// File: tb/tb_cim_wload_ctrl.sv
// Self-checking bench for cim_wload_ctrl: randomized bursts against a row-level bank model.
module tb_cim_wload_ctrl;

    localparam int DW = 24;
    localparam int RW = 8;
    localparam int HW = DW / 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [2:0]    base_row = '0;
    logic [3:0]    row_count = '0;
    logic [DW-1:0] D;
    logic [RW-1:0] WA;
    logic          wr_strobe, busy, done;

    cim_wload_ctrl_if #(.DATA_W(DW)) sif ();

`ifdef CIM_WLOAD_READBACK_EN
    logic [RW*HW-1:0] WB_a, WB_b;
    logic             rb_err;
    bit               stuck_en = 1'b0;
    logic             exp_rb = 1'b0;
    logic [DW-1:0]    view [RW];
`endif

    cim_wload_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .base_row  (base_row),
        .row_count (row_count),
        .abort     (abort),
        .s         (sif),
        .D         (D),
        .WA        (WA),
        .wr_strobe (wr_strobe),
        .busy      (busy),
        .done      (done)
`ifdef CIM_WLOAD_READBACK_EN
       ,.WB_a      (WB_a),
        .WB_b      (WB_b),
        .rb_err    (rb_err)
`endif
    );

    always #5 clk = ~clk;

    int            errors = 0;
    int            checks = 0;
    int            strobe_cnt = 0;
    logic [DW-1:0] bank     [RW];
    logic [DW-1:0] exp_bank [RW];
    logic [RW+DW-1:0] obs_q[$];
    logic [RW+DW-1:0] exp_q[$];
    logic [RW-1:0] exp_wa;
    logic [DW-1:0] exp_d;
    logic [DW-1:0] bdata[$];

    // Bank: the selected row takes D for as long as it is presented.
    always @(negedge clk) begin
        for (int r = 0; r < RW; r++)
            if (WA[r]) bank[r] = D;
    end

    always @(negedge clk) begin
        if (wr_strobe) begin
            strobe_cnt++;
            obs_q.push_back({WA, D});
        end
    end

`ifdef CIM_WLOAD_READBACK_EN
    always_comb begin
        for (int r = 0; r < RW; r++)
            view[r] = WA[r] ? D : bank[r];
    end

    always_comb begin
        WB_a = '0;
        WB_b = '0;
        for (int r = 0; r < RW; r++) begin
            WB_a[r*HW +: HW] = ~view[r][HW-1:0];
            WB_b[r*HW +: HW] = ~view[r][DW-1:HW];
        end
        if (stuck_en) WB_a[2*HW+5] = 1'b1;
    end
`endif

    // One burst from start to the first idle cycle, checked every cycle.
    task automatic run_burst(input string tag, input int base, input int cnt_req,
                             input int gap_pct, input int abort_beat, input int glitch_beat);
        int   cnt, hs, phase, cyc, strobes0, row;
        logic er, eb, ed, es;
        bit   ok;
        cnt = (cnt_req > RW) ? RW : cnt_req;
        hs = 0; cyc = 0; es = 1'b0;
        strobes0 = strobe_cnt;
        obs_q.delete();
        exp_q.delete();
        @(negedge clk);
        start = 1'b1; base_row = 3'(base); row_count = 4'(cnt_req);
`ifdef CIM_WLOAD_READBACK_EN
        exp_rb = 1'b0;
`endif
        phase = (cnt == 0) ? 2 : 1;
        while (cyc < 300) begin
            @(negedge clk);
            er = (phase == 1); eb = (phase != 0); ed = (phase == 2);
            checks++;
            if ({sif.s_ready, busy, done, wr_strobe, WA, D} !== {er, eb, ed, es, exp_wa, exp_d}) begin
                errors++;
                $display("FAIL %s cyc%0d rdy/busy/done/strb/WA/D got %b%b%b%b %h %h exp %b%b%b%b %h %h",
                         tag, cyc, sif.s_ready, busy, done, wr_strobe, WA, D, er, eb, ed, es, exp_wa, exp_d);
            end
`ifdef CIM_WLOAD_READBACK_EN
            checks++;
            if (rb_err !== exp_rb) begin
                errors++;
                $display("FAIL %s cyc%0d rb_err got %b exp %b", tag, cyc, rb_err, exp_rb);
            end
`endif
            start = 1'b0; sif.s_valid = 1'b0; abort = 1'b0; es = 1'b0;
            if (phase == 0) break;
            sif.s_data = DW'($urandom);
            if (phase == 2) begin
                phase = 0;
            end else begin
                if (hs == glitch_beat) begin
                    start = 1'b1; base_row = 3'($urandom); row_count = 4'($urandom_range(1, 8));
                end
                if (hs == abort_beat) begin
                    sif.s_valid = 1'b1; sif.s_data = bdata[hs]; abort = 1'b1;
                    phase = 0;
                end else if ($urandom_range(99) >= gap_pct) begin
                    sif.s_valid = 1'b1; sif.s_data = bdata[hs];
                    row = (base + hs) % RW;
                    exp_wa = RW'(1) << row;
                    exp_d  = bdata[hs];
                    exp_bank[row] = bdata[hs];
                    exp_q.push_back({exp_wa, exp_d});
                    es = 1'b1;
`ifdef CIM_WLOAD_READBACK_EN
                    if (stuck_en && row == 2 && bdata[hs][5]) exp_rb = 1'b1;
`endif
                    hs++;
                    if (hs == cnt) phase = 2;
                end
            end
            cyc++;
        end
        checks++;
        if (cyc >= 300) begin
            errors++;
            $display("FAIL %s timeout got %0d cycles limit 300", tag, cyc);
        end
        #1;
        checks++;
        if (strobe_cnt - strobes0 !== hs) begin
            errors++;
            $display("FAIL %s strobe_count got %0d exp %0d", tag, strobe_cnt - strobes0, hs);
        end
        ok = (obs_q.size() == exp_q.size());
        if (ok) foreach (exp_q[i]) if (obs_q[i] !== exp_q[i]) ok = 1'b0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s write_log got %0d entries exp %0d (first got %h exp %h)", tag,
                     obs_q.size(), exp_q.size(),
                     (obs_q.size() > 0) ? obs_q[0] : '0, (exp_q.size() > 0) ? exp_q[0] : '0);
        end
        for (int r = 0; r < RW; r++) begin
            checks++;
            if (bank[r] !== exp_bank[r]) begin
                errors++;
                $display("FAIL %s bank_row%0d got %h exp %h", tag, r, bank[r], exp_bank[r]);
            end
        end
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if ({sif.s_ready, busy, done, wr_strobe, WA, D} !== {4'b0000, 8'h01, 24'h0}) begin
            errors++;
            $display("FAIL reset rdy/busy/done/strb/WA/D got %b%b%b%b %h %h exp 0000 01 000000",
                     sif.s_ready, busy, done, wr_strobe, WA, D);
        end
`ifdef CIM_WLOAD_READBACK_EN
        checks++;
        if (rb_err !== 1'b0) begin
            errors++;
            $display("FAIL reset rb_err got %b exp 0", rb_err);
        end
`endif
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_full_burst();
        bdata.delete();
        for (int i = 0; i < 8; i++) bdata.push_back(DW'(i + 1));
        run_burst("full_burst", 0, 8, 0, -1, -1);
    endtask

    task automatic test_wrap_gaps();
        bdata = '{24'hA0A0A0, 24'hB1B1B1, 24'hC2C2C2, 24'hD3D3D3};
        run_burst("wrap_gaps", 6, 4, 40, -1, -1);
    endtask

    task automatic test_zero_count();
        run_burst("zero_count", int'($urandom_range(0, 7)), 0, 0, -1, -1);
    endtask

    task automatic test_start_ignored();
        bdata.delete();
        for (int i = 0; i < 5; i++) bdata.push_back(DW'($urandom));
        run_burst("start_ignored", 2, 5, 20, -1, 2);
    endtask

    task automatic test_abort();
        bdata.delete();
        for (int i = 0; i < 5; i++) bdata.push_back(DW'($urandom));
        run_burst("abort", 1, 5, 0, 2, -1);
        bdata.delete();
        for (int i = 0; i < 3; i++) bdata.push_back(DW'($urandom));
        run_burst("after_abort", 4, 3, 0, -1, -1);
    endtask

    task automatic test_saturate();
        bdata.delete();
        for (int i = 0; i < 8; i++) bdata.push_back(DW'($urandom));
        run_burst("saturate", 5, 12, 10, -1, -1);
    endtask

    task automatic test_random();
        for (int n = 0; n < 6; n++) begin
            bdata.delete();
            for (int i = 0; i < 8; i++) bdata.push_back(DW'($urandom));
            run_burst($sformatf("random%0d", n), int'($urandom_range(0, 7)),
                      int'($urandom_range(0, 8)), int'($urandom_range(0, 50)), -1, -1);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        start = 1'b1; base_row = 3'd3; row_count = 4'd6;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            sif.s_valid = 1'b1; sif.s_data = DW'($urandom);
            exp_bank[3 + i] = sif.s_data;
            @(negedge clk);
        end
        sif.s_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        exp_wa = 8'h01; exp_d = '0; exp_bank[0] = '0;
        checks++;
        if ({sif.s_ready, busy, done, wr_strobe, WA, D} !== {4'b0000, exp_wa, exp_d}) begin
            errors++;
            $display("FAIL reset_mid rdy/busy/done/strb/WA/D got %b%b%b%b %h %h exp 0000 01 000000",
                     sif.s_ready, busy, done, wr_strobe, WA, D);
        end
`ifdef CIM_WLOAD_READBACK_EN
        exp_rb = 1'b0;
`endif
        @(negedge clk);
        #1;
        for (int r = 0; r < RW; r++) begin
            checks++;
            if (bank[r] !== exp_bank[r]) begin
                errors++;
                $display("FAIL reset_mid bank_row%0d got %h exp %h", r, bank[r], exp_bank[r]);
            end
        end
        rst_n = 1'b1;
    endtask

`ifdef CIM_WLOAD_READBACK_EN
    task automatic test_readback();
        stuck_en = 1'b1;
        bdata.delete();
        for (int i = 0; i < 4; i++) bdata.push_back(DW'($urandom));
        bdata[2] = bdata[2] | 24'h000020;
        run_burst("readback_stuck", 0, 4, 20, -1, -1);
        checks++;
        if (rb_err !== 1'b1) begin
            errors++;
            $display("FAIL readback_sticky rb_err got %b exp 1", rb_err);
        end
        stuck_en = 1'b0;
        bdata.delete();
        for (int i = 0; i < 2; i++) bdata.push_back(DW'($urandom));
        run_burst("readback_clear", 4, 2, 0, -1, -1);
    endtask
`endif

    initial begin
        sif.s_valid = 1'b0;
        sif.s_data  = '0;
        for (int r = 0; r < RW; r++) begin
            bank[r]     = '0;
            exp_bank[r] = '0;
        end
        exp_wa = 8'h01;
        exp_d  = '0;
        test_reset();
        test_full_burst();
        test_wrap_gaps();
        test_zero_count();
        test_start_ignored();
        test_abort();
        test_saturate();
        test_random();
        test_reset_mid();
`ifdef CIM_WLOAD_READBACK_EN
        test_readback();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
